// File: rtl/rob_param.sv
// Parametrised circular reorder buffer.
// Entries are allocated in program order at the tail. Results arrive on
// NUM_WB writeback channels. One completed entry retires per cycle from the
// head. A retiring entry with br_en set raises flush and empties the buffer.
module rob_param #(
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int NUM_WB = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  // dispatch / allocation
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [IDX_W-1:0]           alloc_idx,
  input  logic [4:0]                 alloc_rd_addr,
  input  logic                       alloc_regf_we,
  input  logic [31:0]                alloc_pc,
  // writeback channels (channel i occupies slice i of each bus)
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]    wb_idx,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  input  logic [NUM_WB-1:0]          wb_br_en,
  input  logic [NUM_WB*32-1:0]       wb_pc_new,
  // in-order commit
  input  logic                       commit_ready,
  output logic                       commit_valid,
  output logic [IDX_W-1:0]           commit_idx,
  output logic [4:0]                 commit_rd_addr,
  output logic                       commit_regf_we,
  output logic [DATA_W-1:0]          commit_rd_data,
  output logic [31:0]                commit_pc,
  output logic [31:0]                commit_pc_new,
  output logic                       flush,
  // occupancy
  output logic [IDX_W:0]             count,
  output logic                       empty,
  output logic                       full
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_ROB_WAIT = 2'd1,
    ST_DONE     = 2'd2
  } status_t;

  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  // Per-entry status (reset) and payload (not reset).
  status_t           r_state    [DEPTH];
  logic [4:0]        r_rd_addr  [DEPTH];
  logic              r_regf_we  [DEPTH];
  logic [31:0]       r_pc       [DEPTH];
  logic [DATA_W-1:0] r_data     [DEPTH];
  logic              r_br_en    [DEPTH];
  logic [31:0]       r_pc_new   [DEPTH];

  // Head/tail pointers carry an extra wrap bit above the index.
  logic [IDX_W:0]    r_head;
  logic [IDX_W:0]    r_tail;

  logic [IDX_W-1:0]  w_head_idx;
  logic [IDX_W-1:0]  w_tail_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_commit_valid;
  logic              w_commit_fire;
  logic              w_flush;
  logic              w_alloc_ready;
  logic              w_alloc_fire;

  logic [IDX_W-1:0]  w_wb_idx    [NUM_WB];
  logic [DATA_W-1:0] w_wb_data   [NUM_WB];
  logic [31:0]       w_wb_pc_new [NUM_WB];
  logic [NUM_WB-1:0] w_wb_take;
  logic [NUM_WB-1:0] w_wb_fire;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

  // Head retires when its result is in; rst forces the handshake outputs low.
  assign w_commit_valid = !rst && !w_empty && (r_state[w_head_idx] == ST_DONE);
  assign w_commit_fire  = w_commit_valid && commit_ready;
  assign w_flush        = w_commit_fire && r_br_en[w_head_idx];

  // A full buffer refuses dispatch even if the head retires this cycle.
  assign w_alloc_ready  = !rst && !w_full && !w_flush;
  assign w_alloc_fire   = alloc_valid && w_alloc_ready;

  // Unpack channel buses and pick one winner per target entry (lowest channel).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_wb_take = '0;
    w_wb_fire = '0;
    for (int i = 0; i < NUM_WB; i++) begin
      w_wb_idx[i]    = wb_idx[i*IDX_W +: IDX_W];
      w_wb_data[i]   = wb_data[i*DATA_W +: DATA_W];
      w_wb_pc_new[i] = wb_pc_new[i*32 +: 32];
    end
    for (int i = 0; i < NUM_WB; i++) begin
      w_wb_take[i] = wb_valid[i];
      for (int j = 0; j < NUM_WB; j++) begin
        if (j < i && wb_valid[j] && (w_wb_idx[j] == w_wb_idx[i])) begin
          w_wb_take[i] = 1'b0;
        end
      end
      // Only entries still waiting accept a result; empty/done entries ignore it.
      w_wb_fire[i] = w_wb_take[i] && !rst && !w_flush &&
                     (r_state[w_wb_idx[i]] == ST_ROB_WAIT);
    end
  end

  // Entry status and pointers: reset/flush clear everything, otherwise apply
  // allocate, writeback and retire (they always touch distinct entries).
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        r_state[i] <= ST_EMPTY;
      end
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_alloc_fire) begin
        r_state[w_tail_idx] <= ST_ROB_WAIT;
        r_tail              <= r_tail + PTR_ONE;
      end
      for (int i = 0; i < NUM_WB; i++) begin
        if (w_wb_fire[i]) begin
          r_state[w_wb_idx[i]] <= ST_DONE;
        end
      end
      if (w_commit_fire) begin
        r_state[w_head_idx] <= ST_EMPTY;
        r_head              <= r_head + PTR_ONE;
      end
    end
  end

  // Entry payload: written on allocate and writeback, qualified by status.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays are deliberately not reset; r_state gates every read so stale contents are never observed.
    if (w_alloc_fire) begin
      r_rd_addr[w_tail_idx] <= alloc_rd_addr;
      r_regf_we[w_tail_idx] <= alloc_regf_we;
      r_pc[w_tail_idx]      <= alloc_pc;
    end
    for (int i = 0; i < NUM_WB; i++) begin
      if (w_wb_fire[i]) begin
        r_data[w_wb_idx[i]]   <= w_wb_data[i];
        r_br_en[w_wb_idx[i]]  <= wb_br_en[i];
        r_pc_new[w_wb_idx[i]] <= w_wb_pc_new[i];
      end
    end
  end

  assign alloc_ready    = w_alloc_ready;
  assign alloc_idx      = w_tail_idx;

  assign commit_valid   = w_commit_valid;
  assign commit_idx     = w_head_idx;
  assign commit_rd_addr = r_rd_addr[w_head_idx];
  assign commit_regf_we = r_regf_we[w_head_idx];
  assign commit_rd_data = r_data[w_head_idx];
  assign commit_pc      = r_pc[w_head_idx];
  assign commit_pc_new  = r_pc_new[w_head_idx];
  assign flush          = w_flush;

  assign count          = r_tail - r_head;
  assign empty          = w_empty;
  assign full           = w_full;

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH=32, NUM_WB=4, DATA_W=32).
// Inputs change 1 ns after posedge; outputs are sampled on the negedge.
module tb_rob_param;

  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;
  localparam int NUM_WB = 4;
  localparam int DATA_W = 32;

  logic                     clk;
  logic                     rst;
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [IDX_W-1:0]         alloc_idx;
  logic [4:0]               alloc_rd_addr;
  logic                     alloc_regf_we;
  logic [31:0]              alloc_pc;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*IDX_W-1:0]  wb_idx;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB-1:0]        wb_br_en;
  logic [NUM_WB*32-1:0]     wb_pc_new;
  logic                     commit_ready;
  logic                     commit_valid;
  logic [IDX_W-1:0]         commit_idx;
  logic [4:0]               commit_rd_addr;
  logic                     commit_regf_we;
  logic [DATA_W-1:0]        commit_rd_data;
  logic [31:0]              commit_pc;
  logic [31:0]              commit_pc_new;
  logic                     flush;
  logic [IDX_W:0]           count;
  logic                     empty;
  logic                     full;

  int n_tests = 0;
  int n_fail  = 0;

  rob_param #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .alloc_rd_addr(alloc_rd_addr), .alloc_regf_we(alloc_regf_we), .alloc_pc(alloc_pc),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .wb_br_en(wb_br_en), .wb_pc_new(wb_pc_new),
    .commit_ready(commit_ready), .commit_valid(commit_valid), .commit_idx(commit_idx),
    .commit_rd_addr(commit_rd_addr), .commit_regf_we(commit_regf_we),
    .commit_rd_data(commit_rd_data), .commit_pc(commit_pc), .commit_pc_new(commit_pc_new),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         alloc_valid;
    logic [31:0]  alloc_pc;
    logic [3:0]   wb_valid;
    logic [19:0]  wb_idx;
    logic [127:0] wb_data;
    logic         commit_ready;
    logic         exp_alloc_ready;
    logic [4:0]   exp_alloc_idx;
    logic         exp_commit_valid;
    logic [4:0]   exp_commit_idx;
    logic [31:0]  exp_data;
    logic [31:0]  exp_pc;
    logic [5:0]   exp_count;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic av, input logic [31:0] pc, input logic [3:0] wv,
                              input logic [19:0] wi, input logic [127:0] wd, input logic cr,
                              input logic ear, input logic [4:0] eai, input logic ecv,
                              input logic [4:0] eci, input logic [31:0] ed, input logic [31:0] ep,
                              input logic [5:0] ec);
    vec_t v;
    v.alloc_valid = av; v.alloc_pc = pc; v.wb_valid = wv; v.wb_idx = wi; v.wb_data = wd;
    v.commit_ready = cr; v.exp_alloc_ready = ear; v.exp_alloc_idx = eai;
    v.exp_commit_valid = ecv; v.exp_commit_idx = eci; v.exp_data = ed; v.exp_pc = ep;
    v.exp_count = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0; alloc_rd_addr = 5'd0; alloc_regf_we = 1'b0; alloc_pc = 32'h0;
    wb_valid = '0; wb_idx = '0; wb_data = '0; wb_br_en = '0; wb_pc_new = '0;
    commit_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input int ch, input logic [4:0] idx, input logic [31:0] data,
                        input logic br, input logic [31:0] pc_new);
    wb_valid[ch]           = 1'b1;
    wb_idx[ch*IDX_W +: IDX_W] = idx;
    wb_data[ch*32 +: 32]   = data;
    wb_br_en[ch]           = br;
    wb_pc_new[ch*32 +: 32] = pc_new;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_inputs();
    alloc_valid = 1'b1;
    commit_ready = 1'b1;
    @(negedge clk);
    check({tag, " rst alloc_ready"}, 64'(alloc_ready), 64'd0);
    check({tag, " rst commit_valid"}, 64'(commit_valid), 64'd0);
    check({tag, " rst flush"}, 64'(flush), 64'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    check({tag, " post count"}, 64'(count), 64'd0);
    check({tag, " post empty"}, 64'(empty), 64'd1);
    check({tag, " post full"}, 64'(full), 64'd0);
    check({tag, " post alloc_ready"}, 64'(alloc_ready), 64'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();

    // ---- table: out-of-order completion, channel conflict, done-entry ignore
    vecs[0]  = mk(1, 32'h1000, 4'b0000, '0, '0, 0, 1, 5'd0, 0, 5'd0, 0, 0, 6'd0);
    vecs[1]  = mk(1, 32'h1004, 4'b0000, '0, '0, 0, 1, 5'd1, 0, 5'd0, 0, 0, 6'd1);
    vecs[2]  = mk(1, 32'h1008, 4'b0000, '0, '0, 0, 1, 5'd2, 0, 5'd0, 0, 0, 6'd2);
    vecs[3]  = mk(0, 32'h0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2},
                  {32'h0, 32'h0, 32'h0, 32'h33}, 0, 1, 5'd3, 0, 5'd0, 0, 0, 6'd3);
    vecs[4]  = mk(0, 32'h0, 4'b0010, {5'd0, 5'd0, 5'd1, 5'd0},
                  {32'h0, 32'h0, 32'h22, 32'h0}, 0, 1, 5'd3, 0, 5'd0, 0, 0, 6'd3);
    vecs[5]  = mk(0, 32'h0, 4'b1000, {5'd0, 5'd0, 5'd0, 5'd0},
                  {32'h11, 32'h0, 32'h0, 32'h0}, 0, 1, 5'd3, 0, 5'd0, 0, 0, 6'd3);
    vecs[6]  = mk(0, 32'h0, 4'b0000, '0, '0, 1, 1, 5'd3, 1, 5'd0, 32'h11, 32'h1000, 6'd3);
    vecs[7]  = mk(0, 32'h0, 4'b0000, '0, '0, 1, 1, 5'd3, 1, 5'd1, 32'h22, 32'h1004, 6'd2);
    vecs[8]  = mk(0, 32'h0, 4'b0000, '0, '0, 1, 1, 5'd3, 1, 5'd2, 32'h33, 32'h1008, 6'd1);
    vecs[9]  = mk(0, 32'h0, 4'b0000, '0, '0, 0, 1, 5'd3, 0, 5'd0, 0, 0, 6'd0);
    vecs[10] = mk(1, 32'h100C, 4'b0000, '0, '0, 0, 1, 5'd3, 0, 5'd0, 0, 0, 6'd0);
    vecs[11] = mk(0, 32'h0, 4'b0101, {5'd0, 5'd3, 5'd0, 5'd3},
                  {32'h0, 32'hB, 32'h0, 32'hA}, 1, 1, 5'd4, 0, 5'd0, 0, 0, 6'd1);
    vecs[12] = mk(0, 32'h0, 4'b0010, {5'd0, 5'd0, 5'd3, 5'd0},
                  {32'h0, 32'h0, 32'hC, 32'h0}, 0, 1, 5'd4, 1, 5'd3, 32'hA, 32'h100C, 6'd1);
    vecs[13] = mk(0, 32'h0, 4'b0000, '0, '0, 1, 1, 5'd4, 1, 5'd3, 32'hA, 32'h100C, 6'd1);
    vecs[14] = mk(0, 32'h0, 4'b0000, '0, '0, 0, 1, 5'd4, 0, 5'd0, 0, 0, 6'd0);

    do_reset("init");

    for (int v = 0; v < NVEC; v++) begin
      alloc_valid   = vecs[v].alloc_valid;
      alloc_pc      = vecs[v].alloc_pc;
      alloc_rd_addr = 5'd7;
      alloc_regf_we = 1'b1;
      wb_valid      = vecs[v].wb_valid;
      wb_idx        = vecs[v].wb_idx;
      wb_data       = vecs[v].wb_data;
      wb_br_en      = '0;
      wb_pc_new     = '0;
      commit_ready  = vecs[v].commit_ready;
      @(negedge clk);
      check($sformatf("v%0d alloc_ready", v), 64'(alloc_ready), 64'(vecs[v].exp_alloc_ready));
      check($sformatf("v%0d alloc_idx", v), 64'(alloc_idx), 64'(vecs[v].exp_alloc_idx));
      check($sformatf("v%0d commit_valid", v), 64'(commit_valid), 64'(vecs[v].exp_commit_valid));
      check($sformatf("v%0d flush", v), 64'(flush), 64'd0);
      check($sformatf("v%0d count", v), 64'(count), 64'(vecs[v].exp_count));
      if (vecs[v].exp_commit_valid) begin
        check($sformatf("v%0d commit_idx", v), 64'(commit_idx), 64'(vecs[v].exp_commit_idx));
        check($sformatf("v%0d commit_rd_data", v), 64'(commit_rd_data), 64'(vecs[v].exp_data));
        check($sformatf("v%0d commit_pc", v), 64'(commit_pc), 64'(vecs[v].exp_pc));
        check($sformatf("v%0d commit_rd_addr", v), 64'(commit_rd_addr), 64'd7);
      end
      tick();
    end
    idle_inputs();

    // ---- fill to full, refused 33rd alloc, no alloc while full even with commit
    do_reset("fill");
    for (int k = 0; k < DEPTH; k++) begin
      alloc_valid = 1'b1;
      alloc_pc    = 32'h3000 + 32'(4 * k);
      @(negedge clk);
      check($sformatf("fill%0d alloc_idx", k), 64'(alloc_idx), 64'(k));
      check($sformatf("fill%0d alloc_ready", k), 64'(alloc_ready), 64'd1);
      tick();
    end
    alloc_valid = 1'b1;
    @(negedge clk);
    check("full flag", 64'(full), 64'd1);
    check("full count", 64'(count), 64'd32);
    check("full alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    check("full 33rd count", 64'(count), 64'd32);
    check("full 33rd alloc_idx", 64'(alloc_idx), 64'd0);
    tick();
    set_wb(1, 5'd0, 32'hEE, 1'b0, 32'h0);
    tick();
    idle_inputs();
    alloc_valid  = 1'b1;
    commit_ready = 1'b1;
    @(negedge clk);
    check("full+commit commit_valid", 64'(commit_valid), 64'd1);
    check("full+commit alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("full+commit count", 64'(count), 64'd31);
    check("full+commit alloc_idx", 64'(alloc_idx), 64'd0);
    check("full+commit full", 64'(full), 64'd0);
    tick();

    // ---- wrap-around from head=tail=30
    do_reset("wrap");
    for (int k = 0; k < 30; k++) begin
      alloc_valid = 1'b1;
      tick();
      idle_inputs();
      set_wb(0, 5'(k), 32'h0, 1'b0, 32'h0);
      tick();
      idle_inputs();
      commit_ready = 1'b1;
      tick();
      idle_inputs();
    end
    @(negedge clk);
    check("wrap start alloc_idx", 64'(alloc_idx), 64'd30);
    check("wrap start count", 64'(count), 64'd0);
    check("wrap start empty", 64'(empty), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      alloc_valid = 1'b1;
      alloc_pc    = 32'h4000 + 32'(k);
      @(negedge clk);
      check($sformatf("wrap alloc%0d idx", k), 64'(alloc_idx), 64'((30 + k) % 32));
    end
    tick();
    idle_inputs();
    @(negedge clk);
    check("wrap count", 64'(count), 64'd4);
    check("wrap full", 64'(full), 64'd0);
    tick();
    for (int k = 0; k < 4; k++) set_wb(k, 5'((30 + k) % 32), 32'h100 + 32'(k), 1'b0, 32'h0);
    tick();
    idle_inputs();
    commit_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("wrap commit%0d valid", k), 64'(commit_valid), 64'd1);
      check($sformatf("wrap commit%0d idx", k), 64'(commit_idx), 64'((30 + k) % 32));
      check($sformatf("wrap commit%0d data", k), 64'(commit_rd_data), 64'(32'h100 + 32'(k)));
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("wrap end empty", 64'(empty), 64'd1);
    tick();

    // ---- branch flush
    do_reset("flush");
    for (int k = 0; k < 5; k++) begin
      alloc_valid   = 1'b1;
      alloc_pc      = 32'h2000 + 32'(4 * k);
      alloc_rd_addr = 5'(k + 1);
      alloc_regf_we = 1'b1;
      tick();
    end
    idle_inputs();
    set_wb(2, 5'd0, 32'h55, 1'b1, 32'h6000_0040);
    tick();
    idle_inputs();
    commit_ready = 1'b1;
    alloc_valid  = 1'b1;
    set_wb(0, 5'd2, 32'h99, 1'b0, 32'h0);
    @(negedge clk);
    check("flush flag", 64'(flush), 64'd1);
    check("flush commit_valid", 64'(commit_valid), 64'd1);
    check("flush commit_pc_new", 64'(commit_pc_new), 64'h6000_0040);
    check("flush commit_pc", 64'(commit_pc), 64'h2000);
    check("flush commit_rd_data", 64'(commit_rd_data), 64'h55);
    check("flush commit_rd_addr", 64'(commit_rd_addr), 64'd1);
    check("flush alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("after flush empty", 64'(empty), 64'd1);
    check("after flush count", 64'(count), 64'd0);
    check("after flush alloc_idx", 64'(alloc_idx), 64'd0);
    check("after flush commit_valid", 64'(commit_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      alloc_valid = 1'b1;
    end
    tick();
    idle_inputs();
    commit_ready = 1'b1;
    @(negedge clk);
    check("realloc count", 64'(count), 64'd3);
    check("realloc commit_valid", 64'(commit_valid), 64'd0);
    tick();
    idle_inputs();

    // ---- alloc + commit + writeback in one cycle, then mid-stream reset
    do_reset("conc");
    alloc_valid = 1'b1;
    tick();
    tick();
    idle_inputs();
    set_wb(0, 5'd0, 32'h66, 1'b0, 32'h0);
    tick();
    idle_inputs();
    alloc_valid  = 1'b1;
    commit_ready = 1'b1;
    set_wb(1, 5'd1, 32'h77, 1'b0, 32'h0);
    @(negedge clk);
    check("conc commit_valid", 64'(commit_valid), 64'd1);
    check("conc commit_rd_data", 64'(commit_rd_data), 64'h66);
    check("conc alloc_ready", 64'(alloc_ready), 64'd1);
    check("conc count before", 64'(count), 64'd2);
    tick();
    idle_inputs();
    @(negedge clk);
    check("conc count after", 64'(count), 64'd2);
    check("conc next commit_valid", 64'(commit_valid), 64'd1);
    check("conc next commit_idx", 64'(commit_idx), 64'd1);
    check("conc next commit_rd_data", 64'(commit_rd_data), 64'h77);
    tick();
    do_reset("mid");
    @(negedge clk);
    check("mid commit_valid", 64'(commit_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
